// File: rtl/prim_sync_reqack_arb.sv
// prim_sync_reqack_arb: source side of a four-phase req/ack clock-domain crossing.
// Round-robin arbitrates between NumReq local requesters, captures the winner's
// payload into a holding register, drives req_o across the crossing and
// synchronizes the returning ack_i before the state machine acts on it.
module prim_sync_reqack_arb #(
  parameter int NumReq = 4,
  parameter int Width  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NumReq-1:0]       req_i,
  input  logic [NumReq*Width-1:0] data_i,
  output logic [NumReq-1:0]       gnt_o,
  output logic [NumReq-1:0]       done_o,
  output logic                    busy_o,
  output logic                    req_o,
  output logic [Width-1:0]        data_o,
  input  logic                    ack_i
);

  localparam int IdxW = $clog2(NumReq);
  localparam logic [NumReq-1:0] OneLsb = NumReq'(1);
  localparam logic [IdxW-1:0]   LastIdx = IdxW'(NumReq - 1);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReq     = 2'd1,
    StRelease = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            ack_q1, ack_q2;
  logic [IdxW-1:0] last_q, cur_idx_q;
  logic [IdxW-1:0] cand, arb_idx;
  logic            arb_valid;
  logic            launch, finish, req_d;
  logic [Width-1:0] data_arr [NumReq];

  // Unpack the flat payload bus so the winner can be selected by index.
  for (genvar gi = 0; gi < NumReq; gi++) begin : g_unpack
    assign data_arr[gi] = data_i[gi*Width +: Width];
  end

  // Two-flop synchronizer for the acknowledge arriving from the far domain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; blocking here would collapse ack_q1/ack_q2.
    if (rst_i) begin
      ack_q1 <= 1'b0;
      ack_q2 <= 1'b0;
    end else begin
      ack_q1 <= ack_i;
      ack_q2 <= ack_q1;
    end
  end

  // Round-robin search starting just after the previous winner.
  always_comb begin
    // NOTE: every combinational output gets a default first; a path that
    // leaves one unassigned would infer a latch.
    arb_valid = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int off = 1; off <= NumReq; off++) begin
      cand = IdxW'((int'(last_q) + off) % NumReq);
      if (!arb_valid && req_i[cand]) begin
        arb_valid = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic plus the next value of the registered req_o.
  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    finish  = 1'b0;
    req_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A still-high synchronized ack means the far side has not released
        // the previous handshake (or is stale after reset): hold off.
        if (arb_valid && !ack_q2) begin
          launch  = 1'b1;
          req_d   = 1'b1;
          state_d = StReq;
        end
      end
      StReq: begin
        req_d = 1'b1;
        if (ack_q2) begin
          req_d   = 1'b0;
          state_d = StRelease;
        end
      end
      StRelease: begin
        if (!ack_q2) begin
          finish  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Registered outputs, holding register and arbitration bookkeeping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_o     <= 1'b0;
      data_o    <= '0;
      gnt_o     <= '0;
      done_o    <= '0;
      last_q    <= LastIdx;
      cur_idx_q <= '0;
    end else begin
      req_o  <= req_d;
      gnt_o  <= launch ? (OneLsb << arb_idx) : '0;
      done_o <= finish ? (OneLsb << cur_idx_q) : '0;
      if (launch) begin
        // Payload is frozen here; the requester is free to change it afterwards.
        data_o    <= data_arr[arb_idx];
        cur_idx_q <= arb_idx;
        last_q    <= arb_idx;
      end
    end
  end

  assign busy_o = (state_q != StIdle);

endmodule

// File: tb/tb_prim_sync_reqack_arb.sv
// Directed testbench for prim_sync_reqack_arb: one task per scenario, each
// checking its own expectations inline, with a simple far-side responder.
module tb_prim_sync_reqack_arb;

  localparam int NumReq = 4;
  localparam int Width  = 16;

  logic                    clk = 1'b0;
  logic                    rst_i;
  logic [NumReq-1:0]       req_i;
  logic [NumReq*Width-1:0] data_i;
  logic [NumReq-1:0]       gnt_o;
  logic [NumReq-1:0]       done_o;
  logic                    busy_o;
  logic                    req_o;
  logic [Width-1:0]        data_o;
  logic                    ack_i;

  int checks   = 0;
  int failures = 0;
  bit far_auto = 1'b0;
  int far_cnt  = 0;

  always #5 clk = ~clk;

  prim_sync_reqack_arb #(.NumReq(NumReq), .Width(Width)) dut (
    .clk_i  (clk),
    .rst_i  (rst_i),
    .req_i  (req_i),
    .data_i (data_i),
    .gnt_o  (gnt_o),
    .done_o (done_o),
    .busy_o (busy_o),
    .req_o  (req_o),
    .data_o (data_o),
    .ack_i  (ack_i)
  );

  // Far-side model: raises ack two cycles after seeing req_o, drops it as
  // soon as req_o is seen low.
  initial begin
    forever begin
      @(negedge clk);
      if (far_auto) begin
        if (req_o && !ack_i) begin
          if (far_cnt == 1) begin
            ack_i   = 1'b1;
            far_cnt = 0;
          end else begin
            far_cnt++;
          end
        end else if (!req_o && ack_i) begin
          ack_i = 1'b0;
        end else begin
          far_cnt = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic wait_gnt(output logic [NumReq-1:0] g);
    int n;
    n = 0;
    g = '0;
    while (g == '0 && n < 50) begin
      @(negedge clk);
      n++;
      checks++;
      if (gnt_o != '0 && done_o != '0) begin
        failures++;
        $display("FAIL gnt_done_overlap gnt_o=%b done_o=%b required one of them zero", gnt_o, done_o);
      end
      if (gnt_o !== '0) g = gnt_o;
    end
    if (g == '0) begin
      checks++;
      failures++;
      $display("FAIL wait_gnt timeout: no gnt_o within 50 cycles");
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_o && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (busy_o) begin
      checks++;
      failures++;
      $display("FAIL wait_idle timeout: busy_o still 1 after 60 cycles");
    end
  endtask

  task automatic test_reset();
    rst_i  = 1'b1;
    req_i  = '0;
    ack_i  = 1'b0;
    data_i = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (req_o !== 1'b0) begin failures++; $display("FAIL reset_req_o got=%b exp=0", req_o); end
    checks++;
    if (data_o !== '0) begin failures++; $display("FAIL reset_data_o got=%h exp=0000", data_o); end
    checks++;
    if (gnt_o !== '0) begin failures++; $display("FAIL reset_gnt_o got=%b exp=0000", gnt_o); end
    checks++;
    if (done_o !== '0) begin failures++; $display("FAIL reset_done_o got=%b exp=0000", done_o); end
    checks++;
    if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy_o got=%b exp=0", busy_o); end
    rst_i = 1'b0;
    @(negedge clk);
  endtask

  // Grants 0,1,2,3 with all four pending, then wrap-around with 4'b1001.
  task automatic test_round_robin();
    int exp_order [6] = '{0, 1, 2, 3, 0, 3};
    logic [NumReq-1:0] g;
    logic [NumReq-1:0] exp_g;
    logic [Width-1:0]  exp_d;
    for (int i = 0; i < NumReq; i++) data_i[i*Width +: Width] = 16'h1000 + 16'(i);
    far_auto = 1'b1;
    req_i    = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      wait_gnt(g);
      exp_g = 4'b0001 << exp_order[k];
      exp_d = 16'h1000 + 16'(exp_order[k]);
      checks++;
      if (g !== exp_g) begin
        failures++;
        $display("FAIL rr_grant_%0d got=%b exp=%b", k, g, exp_g);
      end
      checks++;
      if (data_o !== exp_d) begin
        failures++;
        $display("FAIL rr_data_%0d got=%h exp=%h", k, data_o, exp_d);
      end
      if (k == 3) req_i = 4'b1001;
      if (k == 5) req_i = 4'b0000;
    end
    wait_idle();
  endtask

  // Single transfer on requester 2 with data changing after the grant.
  task automatic test_single_transfer();
    int req_cnt;
    int done_cyc;
    far_auto = 1'b1;
    data_i[2*Width +: Width] = 16'hA5A5;
    @(negedge clk);
    req_i = 4'b0100;
    @(negedge clk);
    checks++;
    if (gnt_o !== 4'b0100) begin failures++; $display("FAIL single_gnt got=%b exp=0100", gnt_o); end
    checks++;
    if (req_o !== 1'b1) begin failures++; $display("FAIL single_req_rise got=%b exp=1", req_o); end
    checks++;
    if (data_o !== 16'hA5A5) begin failures++; $display("FAIL single_data got=%h exp=a5a5", data_o); end
    req_i    = 4'b0000;
    req_cnt  = 1;
    done_cyc = -1;
    for (int cyc = 2; cyc <= 30 && done_cyc < 0; cyc++) begin
      data_i[2*Width +: Width] = 16'(cyc * 16'h0101);
      @(negedge clk);
      if (req_o) req_cnt++;
      checks++;
      if (data_o !== 16'hA5A5) begin
        failures++;
        $display("FAIL isolation_data cyc=%0d got=%h exp=a5a5", cyc, data_o);
      end
      checks++;
      if (gnt_o !== '0) begin
        failures++;
        $display("FAIL single_extra_gnt cyc=%0d got=%b exp=0000", cyc, gnt_o);
      end
      if (done_o !== '0) begin
        done_cyc = cyc;
        checks++;
        if (done_o !== 4'b0100) begin failures++; $display("FAIL single_done got=%b exp=0100", done_o); end
        checks++;
        if (busy_o !== 1'b0) begin failures++; $display("FAIL single_idle_at_done got=%b exp=0", busy_o); end
      end
    end
    checks++;
    if (req_cnt !== 4) begin failures++; $display("FAIL single_req_width got=%0d exp=4", req_cnt); end
    checks++;
    if (done_cyc !== 8) begin failures++; $display("FAIL single_done_cycle got=%0d exp=8", done_cyc); end
    @(negedge clk);
    checks++;
    if (done_o !== '0) begin failures++; $display("FAIL single_done_pulse got=%b exp=0000", done_o); end
    @(negedge clk);
    checks++;
    if (data_o !== 16'hA5A5) begin failures++; $display("FAIL isolation_idle got=%h exp=a5a5", data_o); end
  endtask

  // ack_i high across reset release: nothing is granted until it drops.
  task automatic test_stale_ack();
    far_auto = 1'b0;
    rst_i    = 1'b1;
    ack_i    = 1'b1;
    req_i    = '0;
    @(negedge clk);
    rst_i = 1'b0;
    repeat (3) @(negedge clk);
    req_i = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (gnt_o !== '0 || req_o !== 1'b0) begin
        failures++;
        $display("FAIL stale_hold i=%0d gnt_o=%b req_o=%b exp gnt_o=0000 req_o=0", i, gnt_o, req_o);
      end
    end
    ack_i = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      checks++;
      if (gnt_o !== '0) begin failures++; $display("FAIL stale_early_gnt i=%0d got=%b exp=0000", i, gnt_o); end
    end
    @(negedge clk);
    checks++;
    if (gnt_o !== 4'b0001) begin failures++; $display("FAIL stale_gnt got=%b exp=0001", gnt_o); end
    checks++;
    if (req_o !== 1'b1) begin failures++; $display("FAIL stale_req got=%b exp=1", req_o); end
    req_i    = '0;
    far_auto = 1'b1;
    wait_idle();
  endtask

  // Reset asserted while in REQ; afterwards requester 0 beats requester 2.
  task automatic test_reset_mid_op();
    far_auto = 1'b0;
    ack_i    = 1'b0;
    data_i[0 +: Width]       = 16'h0F0F;
    data_i[2*Width +: Width] = 16'hBEEF;
    @(negedge clk);
    req_i = 4'b0100;
    @(negedge clk);
    checks++;
    if (gnt_o !== 4'b0100 || data_o !== 16'hBEEF) begin
      failures++;
      $display("FAIL midrst_gnt gnt_o=%b data_o=%h exp 0100 beef", gnt_o, data_o);
    end
    req_i = '0;
    @(negedge clk);
    checks++;
    if (req_o !== 1'b1) begin failures++; $display("FAIL midrst_in_req got=%b exp=1", req_o); end
    #1 rst_i = 1'b1;
    #1;
    checks++;
    if (req_o !== 1'b0) begin failures++; $display("FAIL midrst_req_o got=%b exp=0", req_o); end
    checks++;
    if (busy_o !== 1'b0) begin failures++; $display("FAIL midrst_busy_o got=%b exp=0", busy_o); end
    checks++;
    if (data_o !== '0) begin failures++; $display("FAIL midrst_data_o got=%h exp=0000", data_o); end
    req_i = 4'b0101;
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt_o !== 4'b0001) begin failures++; $display("FAIL midrst_regrant got=%b exp=0001", gnt_o); end
    checks++;
    if (done_o !== '0) begin failures++; $display("FAIL midrst_no_done got=%b exp=0000", done_o); end
    checks++;
    if (data_o !== 16'h0F0F) begin failures++; $display("FAIL midrst_data got=%h exp=0f0f", data_o); end
    req_i    = '0;
    far_auto = 1'b1;
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_transfer();
    test_stale_ack();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
